cache_control_burst: RTL and testbench
======================================

Name: cache_control_burst

Overview:
Parametrised successor to the single-word cache controller FSM, for a direct-mapped, write-through cache. Refills whole lines of 2**BEAT_W words through a SysReady beat handshake, and invalidates the line before each refill. Sits between the processor port (PStrobe/PRw/PReady) and the system bus. Drives the enables and muxes of the external tag and data RAM.

Parameters:
BEAT_W, 2, log2 of words per line; line = 2**BEAT_W words; legal range 1..4

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears state, beat counter, pending flag
PStrobe  input  1  processor request, sampled in IDLE only
PRw  input  1  1 = read, 0 = write; sampled with PStrobe
PReady  output  1  one-cycle completion pulse to processor
SysStrobe  output  1  one-cycle system request pulse
SysRW  output  1  1 = system read (line fill), 0 = system write
SysReady  input  1  system beat/complete, honoured only in READSYS/WRITESYS
tag_match  input  1  tag RAM compare result, sampled in READ/WRITE
valid  input  1  valid bit of indexed line, sampled in READ/WRITE
write  output  1  data RAM word write enable
write_tag  output  1  tag RAM write plus valid set
inval  output  1  clear valid of indexed line
beat  output  BEAT_W  word offset of current fill beat
select_CacheData  output  1  processor read data from cache RAM
select_PData  output  1  cache RAM write data from processor (0 = from system bus)

Behaviour:
- Reset: state IDLE; beat=0; pending=0; all outputs 0. Asynchronous assertion takes effect immediately, including mid-burst.
- Outputs are decoded from registered state. write and write_tag in READSYS are also gated by SysReady.
- IDLE: PStrobe&PRw -> READ; PStrobe&!PRw -> WRITE; otherwise stay. PStrobe outside IDLE is ignored.
- READ: hit = tag_match&valid. Hit -> READDATA; miss -> READMISS.
- READMISS: inval=1, SysStrobe=1, SysRW=1, beat<=0 -> READSYS.
- READSYS: SysRW=1, select_PData=0.
  - On SysReady: write=1 and beat<=beat+1.
  - On SysReady with beat==2**BEAT_W-1: write_tag=1, beat<=0 -> READDATA.
  - Without SysReady: hold.
- READDATA: PReady=1, select_CacheData=1 -> IDLE.
- Read hit latency: strobe at cycle T gives PReady at T+2. Miss gives PReady one cycle after the last SysReady.
- WRITE: hit -> WRITEHIT; miss -> WRITEMISS.
- WRITEHIT: write=1, select_PData=1, SysStrobe=1, SysRW=0 -> WRITESYS.
- WRITEMISS: SysStrobe=1, SysRW=0; cache untouched (no-write-allocate) -> WRITESYS.
- WRITESYS: SysRW=0; wait for SysReady -> WRITEDATA.
- WRITEDATA: PReady=1 -> IDLE.
- SysReady in the same cycle as SysStrobe (i.e. in READMISS/WRITEHIT/WRITEMISS) is not honoured; the system responds no earlier than the following cycle.
- Beat counter wraps to 0 after the last beat, and never exceeds 2**BEAT_W-1.
- Reset during READSYS: the line stays invalid because inval was issued and write_tag was not. The next access to that line misses.
- SysStrobe is never high for two consecutive cycles. PReady is never high for two consecutive cycles.

Optional Feature:
CACHE_WRITE_ALLOCATE_EN
- Defined: a write miss sets pending=1 and goes READMISS -> READSYS (full line fill as for reads).
  - After the last beat, pending=1 routes to WRITEHIT instead of READDATA, then clears pending.
  - WRITEHIT then writes the word and issues the system write as normal.
- Undefined: the pending register is absent; write misses follow WRITEMISS (no-write-allocate).

Test Plan:
1. Read hit: reset, PStrobe=1 PRw=1 at T, tag_match=valid=1 -> PReady=1 and select_CacheData=1 at T+2; SysStrobe stays 0.
2. Read miss, BEAT_W=2, SysReady high 1 cycle in every 2 -> inval+SysStrobe at T+2; 4 write pulses with beat=0,1,2,3; write_tag with beat 3; PReady the cycle after the 4th SysReady.
3. Write hit, SysReady 3 cycles after SysStrobe -> write=1, select_PData=1, SysStrobe=1, SysRW=0 in the same cycle; PReady exactly 1 cycle after SysReady.
4. Write miss without macro -> write stays 0, single SysStrobe; with CACHE_WRITE_ALLOCATE_EN -> 4-beat fill, then write=1 with select_PData=1, then PReady.
5. Reset asserted after 2nd fill beat -> all outputs 0 asynchronously, beat=0; a following read of the same line (valid=0) misses again.
6. PStrobe held high during a read-miss burst plus SysReady pulsed in IDLE -> no extra SysStrobe, no write; exactly one PReady per accepted request.

Source files
------------

// File: rtl/cache_control_burst.sv
// Direct-mapped write-through cache controller with 2**BEAT_W-word line refill.
// Optional CACHE_WRITE_ALLOCATE_EN: write misses fill the line first, then write as a hit.
module cache_control_burst #(
    parameter int BEAT_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              PStrobe,
    input  logic              PRw,
    output logic              PReady,
    output logic              SysStrobe,
    output logic              SysRW,
    input  logic              SysReady,
    input  logic              tag_match,
    input  logic              valid,
    output logic              write,
    output logic              write_tag,
    output logic              inval,
    output logic [BEAT_W-1:0] beat,
    output logic              select_CacheData,
    output logic              select_PData
);

    // state     | meaning
    // IDLE      | waiting for a processor strobe
    // READ      | tag compare for a read
    // READMISS  | invalidate line, issue line-fill request
    // READSYS   | collect fill beats, last beat writes tag
    // READDATA  | return cached word to processor
    // WRITE     | tag compare for a write
    // WRITEHIT  | update cached word, issue system write
    // WRITEMISS | issue system write, cache untouched
    // WRITESYS  | wait for system write completion
    // WRITEDATA | acknowledge processor write
    typedef enum logic [3:0] {
        IDLE, READ, READMISS, READSYS, READDATA,
        WRITE, WRITEHIT, WRITEMISS, WRITESYS, WRITEDATA
    } state_t;

    localparam logic [BEAT_W-1:0] LAST_BEAT = '1;

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              hit;

    assign hit  = tag_match & valid;
    assign beat = beat_q;

`ifdef CACHE_WRITE_ALLOCATE_EN
    logic pending_q, pending_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) pending_q <= 1'b0;
        else       pending_q <= pending_d;
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        beat_d           = beat_q;
`ifdef CACHE_WRITE_ALLOCATE_EN
        pending_d        = pending_q;
`endif
        PReady           = 1'b0;
        SysStrobe        = 1'b0;
        SysRW            = 1'b0;
        write            = 1'b0;
        write_tag        = 1'b0;
        inval            = 1'b0;
        select_CacheData = 1'b0;
        select_PData     = 1'b0;

        case (state_q)
            IDLE: begin
                if (PStrobe) state_d = PRw ? READ : WRITE;
            end
            READ: begin
                state_d = hit ? READDATA : READMISS;
            end
            READMISS: begin
                inval     = 1'b1;
                SysStrobe = 1'b1;
                SysRW     = 1'b1;
                beat_d    = '0;
                state_d   = READSYS;
            end
            READSYS: begin
                SysRW = 1'b1;
                if (SysReady) begin
                    write = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        write_tag = 1'b1;
                        beat_d    = '0;
`ifdef CACHE_WRITE_ALLOCATE_EN
                        state_d   = pending_q ? WRITEHIT : READDATA;
                        pending_d = 1'b0;
`else
                        state_d   = READDATA;
`endif
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            READDATA: begin
                PReady           = 1'b1;
                select_CacheData = 1'b1;
                state_d          = IDLE;
            end
            WRITE: begin
                if (hit) begin
                    state_d = WRITEHIT;
                end else begin
`ifdef CACHE_WRITE_ALLOCATE_EN
                    pending_d = 1'b1;
                    state_d   = READMISS;
`else
                    state_d   = WRITEMISS;
`endif
                end
            end
            WRITEHIT: begin
                write        = 1'b1;
                select_PData = 1'b1;
                SysStrobe    = 1'b1;
                state_d      = WRITESYS;
            end
            WRITEMISS: begin
                SysStrobe = 1'b1;
                state_d   = WRITESYS;
            end
            WRITESYS: begin
                if (SysReady) state_d = WRITEDATA;
            end
            WRITEDATA: begin
                PReady  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_control_burst.sv
// Directed self-checking bench for cache_control_burst (BEAT_W=2).
module tb_cache_control_burst;

    logic       clock = 1'b0;
    logic       reset;
    logic       PStrobe, PRw, SysReady, tag_match, valid;
    logic       PReady, SysStrobe, SysRW, write, write_tag, inval;
    logic       select_CacheData, select_PData;
    logic [1:0] beat;

    int n_tests = 0;
    int n_fail  = 0;
    int n_ss = 0, n_pr = 0, n_wr = 0, bad_ss = 0, bad_pr = 0;
    logic prev_ss = 1'b0, prev_pr = 1'b0;

    cache_control_burst #(.BEAT_W(2)) dut (
        .clock(clock), .reset(reset), .PStrobe(PStrobe), .PRw(PRw),
        .PReady(PReady), .SysStrobe(SysStrobe), .SysRW(SysRW), .SysReady(SysReady),
        .tag_match(tag_match), .valid(valid), .write(write), .write_tag(write_tag),
        .inval(inval), .beat(beat), .select_CacheData(select_CacheData),
        .select_PData(select_PData)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Settle, tally pulses of the current cycle, then advance one clock.
    task automatic tick();
        #1;
        n_ss += int'(SysStrobe);
        n_pr += int'(PReady);
        n_wr += int'(write);
        if (prev_ss && SysStrobe) bad_ss++;
        if (prev_pr && PReady) bad_pr++;
        prev_ss = SysStrobe;
        prev_pr = PReady;
        @(posedge clock);
        #1;
    endtask

    task automatic clr_counts();
        n_ss = 0; n_pr = 0; n_wr = 0; bad_ss = 0; bad_pr = 0;
    endtask

    task automatic fill_beats(input string tag, input bit gap);
        for (int i = 0; i < 4; i++) begin
            if (gap) begin
                SysReady = 1'b0; #1;
                check({tag, "_gap_write"}, 32'(write), 0);
                tick();
            end
            SysReady = 1'b1; #1;
            check({tag, "_write"}, 32'(write), 1);
            check({tag, "_beat"}, 32'(beat), 32'(i));
            check({tag, "_write_tag"}, 32'(write_tag), 32'(i == 3));
            tick();
        end
        SysReady = 1'b0;
    endtask

    initial begin
        reset = 1'b1; PStrobe = 0; PRw = 0; SysReady = 0; tag_match = 0; valid = 0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_outputs", 32'({PReady, SysStrobe, SysRW, write, write_tag, inval,
                                  select_CacheData, select_PData}), 0);
        check("rst_beat", 32'(beat), 0);
        reset = 1'b0;
        clr_counts();

        // Read hit
        PStrobe = 1; PRw = 1; tick();
        PStrobe = 0; tag_match = 1; valid = 1; tick();
        check("rh_pready", 32'(PReady), 1);
        check("rh_selcd", 32'(select_CacheData), 1);
        check("rh_sysstrobe", 32'(SysStrobe), 0);
        tick();
        check("rh_pready_off", 32'(PReady), 0);

        // Read miss with SysReady every other cycle
        PStrobe = 1; PRw = 1; tick();
        PStrobe = 0; tag_match = 0; valid = 1; tick();
        check("rm_inval", 32'(inval), 1);
        check("rm_sysstrobe", 32'(SysStrobe), 1);
        check("rm_sysrw", 32'(SysRW), 1);
        tick();
        check("rm_sysstrobe_once", 32'(SysStrobe), 0);
        fill_beats("rm", 1'b1);
        #1;
        check("rm_pready", 32'(PReady), 1);
        tick();
        check("rm_pready_off", 32'(PReady), 0);

        // Write hit, SysReady three cycles after SysStrobe
        PStrobe = 1; PRw = 0; tick();
        PStrobe = 0; tag_match = 1; valid = 1; tick();
        check("wh_write", 32'(write), 1);
        check("wh_selpd", 32'(select_PData), 1);
        check("wh_sysstrobe", 32'(SysStrobe), 1);
        check("wh_sysrw", 32'(SysRW), 0);
        tick();
        check("wh_ss_off", 32'(SysStrobe), 0);
        tick();
        check("wh_wait_pready", 32'(PReady), 0);
        tick();
        SysReady = 1; #1;
        check("wh_sr_pready", 32'(PReady), 0);
        tick();
        SysReady = 0;
        check("wh_pready", 32'(PReady), 1);
        tick();
        check("wh_pready_off", 32'(PReady), 0);

        // Write miss
        clr_counts();
        PStrobe = 1; PRw = 0; tick();
        PStrobe = 0; tag_match = 0; valid = 1; tick();
`ifdef CACHE_WRITE_ALLOCATE_EN
        check("wa_inval", 32'(inval), 1);
        check("wa_sysstrobe", 32'(SysStrobe), 1);
        check("wa_sysrw", 32'(SysRW), 1);
        tick();
        fill_beats("wa", 1'b0);
        #1;
        check("wa_write", 32'(write), 1);
        check("wa_selpd", 32'(select_PData), 1);
        check("wa_sysstrobe2", 32'(SysStrobe), 1);
        check("wa_sysrw2", 32'(SysRW), 0);
        check("wa_pready_early", 32'(PReady), 0);
        tick();
        SysReady = 1; tick();
        SysReady = 0;
        check("wa_pready", 32'(PReady), 1);
        tick();
        check("wa_ss_count", 32'(n_ss), 2);
        check("wa_write_count", 32'(n_wr), 5);
`else
        check("wm_sysstrobe", 32'(SysStrobe), 1);
        check("wm_sysrw", 32'(SysRW), 0);
        check("wm_write", 32'(write), 0);
        check("wm_inval", 32'(inval), 0);
        tick();
        SysReady = 1; #1;
        check("wm_sys_write", 32'(write), 0);
        tick();
        SysReady = 0;
        check("wm_pready", 32'(PReady), 1);
        tick();
        check("wm_ss_count", 32'(n_ss), 1);
        check("wm_write_count", 32'(n_wr), 0);
`endif

        // Reset after the second fill beat
        PStrobe = 1; PRw = 1; tick();
        PStrobe = 0; tag_match = 0; valid = 1; tick();
        tick();
        SysReady = 1; tick(); tick();
        SysReady = 0;
        check("rs_beat_pre", 32'(beat), 2);
        #2 reset = 1'b1;
        #1;
        check("rs_outputs", 32'({PReady, SysStrobe, SysRW, write, write_tag, inval,
                                 select_CacheData, select_PData}), 0);
        check("rs_beat", 32'(beat), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        PStrobe = 1; PRw = 1; tick();
        PStrobe = 0; tag_match = 1; valid = 0; tick();
        check("rs_remiss_inval", 32'(inval), 1);
        check("rs_remiss_ss", 32'(SysStrobe), 1);
        tick();
        fill_beats("rs", 1'b0);
        tick();

        // PStrobe held during a miss burst; SysReady pulsed in IDLE
        clr_counts();
        PStrobe = 1; PRw = 1; tick();
        tag_match = 0; valid = 1; tick();
        tick();
        SysReady = 1;
        for (int i = 0; i < 4; i++) tick();
        SysReady = 0;
        #1;
        check("ps_pready", 32'(PReady), 1);
        PStrobe = 0; tick();
        SysReady = 1; #1;
        check("ps_idle_write", 32'(write), 0);
        check("ps_idle_ss", 32'(SysStrobe), 0);
        tick(); tick();
        SysReady = 0;
        check("ps_idle_beat", 32'(beat), 0);
        check("ps_ss_count", 32'(n_ss), 1);
        check("ps_pready_count", 32'(n_pr), 1);
        check("ps_write_count", 32'(n_wr), 4);
        check("ps_ss_back2back", 32'(bad_ss), 0);
        check("ps_pr_back2back", 32'(bad_pr), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
